// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared dispatcher constants and helpers for the RAM-backed FWFT FIFO front end.
// Default geometry, count width and the depth/address consistency check live here.
package ram_fifo_ctrl_pkg;

    localparam int DEF_WORD_SIZE = 16;
    localparam int DEF_ADDR_SIZE = 5;
    localparam int DEF_DEPTH     = 2 ** DEF_ADDR_SIZE;

    // Pointers wrap for free only when the RAM is exactly a power of two deep.
    function automatic bit depth_ok(input int depth, input int addr_size);
        return depth == (1 << addr_size);
    endfunction

    // One extra bit holds 0..DEPTH+1 (RAM contents plus the word on the read register).
    function automatic int cnt_width(input int addr_size);
        return addr_size + 1;
    endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Producer, consumer and RAM-port signals of the FIFO front end.
// master: the controller itself; slave: the parent or testbench around it.
interface ram_fifo_ctrl_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 5
);
    logic                 flush;
    logic                 in_valid;
    logic [WORD_SIZE-1:0] in_word;
    logic                 in_ready;
    logic                 out_valid;
    logic [WORD_SIZE-1:0] out_word;
    logic                 out_ready;
    logic [ADDR_SIZE:0]   count;
    logic                 empty;
    logic                 full;
    logic                 ram_wr_en;
    logic [ADDR_SIZE-1:0] ram_wr_addr;
    logic [WORD_SIZE-1:0] ram_wr_word;
    logic                 ram_rd_en;
    logic [ADDR_SIZE-1:0] ram_rd_addr;
    logic [WORD_SIZE-1:0] ram_rd_word;

    modport master (
        input  flush, in_valid, in_word, out_ready, ram_rd_word,
        output in_ready, out_valid, out_word, count, empty, full,
               ram_wr_en, ram_wr_addr, ram_wr_word, ram_rd_en, ram_rd_addr
    );

    modport slave (
        output flush, in_valid, in_word, out_ready, ram_rd_word,
        input  in_ready, out_valid, out_word, count, empty, full,
               ram_wr_en, ram_wr_addr, ram_wr_word, ram_rd_en, ram_rd_addr
    );

endinterface

// File: rtl/ram_fifo_ctrl.sv
// Turns a registered two-port RAM into a first-word-fall-through FIFO; the RAM read register is the output holding register.
// Latency: push at t -> out_valid at t+2. in_ready drops when the RAM is full; a stalled head blocks further reads.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int DEPTH     = 2 ** ADDR_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    ram_fifo_ctrl_if.master        fifo
);

    localparam int CNT_W = cnt_width(ADDR_SIZE);

    if (!depth_ok(DEPTH, ADDR_SIZE)) begin : g_bad_depth
        $error("ram_fifo_ctrl: DEPTH must equal 2**ADDR_SIZE");
    end

    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     ram_cnt_q, ram_cnt_d;
    logic                 head_vld_q, head_vld_d;
    logic                 push;
    logic                 rd_go;
    logic                 in_rdy;

    always_comb begin
        in_rdy = (ram_cnt_q != CNT_W'(DEPTH)) && !fifo.flush;
        push   = fifo.in_valid && in_rdy;
        // Only refill the read register once its word is gone or leaving this cycle.
        rd_go  = (ram_cnt_q != '0) && (!head_vld_q || fifo.out_ready) && !fifo.flush;
    end

    always_comb begin
        fifo.in_ready    = in_rdy;
        fifo.full        = !in_rdy;
        fifo.out_valid   = head_vld_q;
        fifo.out_word    = fifo.ram_rd_word;
        fifo.count       = ram_cnt_q + CNT_W'(head_vld_q);
        fifo.empty       = (ram_cnt_q == '0) && !head_vld_q;
        fifo.ram_wr_en   = push;
        fifo.ram_wr_addr = wr_ptr_q;
        fifo.ram_wr_word = fifo.in_word;
        fifo.ram_rd_en   = rd_go;
        fifo.ram_rd_addr = rd_ptr_q;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + ADDR_SIZE'(push);
        rd_ptr_d   = rd_ptr_q + ADDR_SIZE'(rd_go);
        ram_cnt_d  = ram_cnt_q + CNT_W'(push) - CNT_W'(rd_go);
        head_vld_d = rd_go ? 1'b1 : (fifo.out_ready ? 1'b0 : head_vld_q);
        if (fifo.flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            ram_cnt_d  = '0;
            head_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            head_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            head_vld_q <= head_vld_d;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural registered two-port RAM alongside.
module tb_ram_fifo_ctrl;

    localparam int WS = 16;
    localparam int AS = 5;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    ram_fifo_ctrl_if #(.WORD_SIZE(WS), .ADDR_SIZE(AS)) bus ();

    ram_fifo_ctrl #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .DEPTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .fifo (bus)
    );

    logic [WS-1:0] mem [32];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ram_rd_word <= '0;
        end else begin
            if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_word;
            if (bus.ram_rd_en) bus.ram_rd_word <= mem[bus.ram_rd_addr];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [WS-1:0] w, input logic ordy, input logic fl);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_word   = w;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst           = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_count",     32'(bus.count), 0);
        chk("rst_empty",     32'(bus.empty), 1);
        chk("rst_in_ready",  32'(bus.in_ready), 1);
        chk("rst_full",      32'(bus.full), 0);
        chk("rst_wr_en",     32'(bus.ram_wr_en), 0);
        chk("rst_rd_en",     32'(bus.ram_rd_en), 0);
        @(negedge clk);
        rst = 1'b1;

        // Fall-through of one word into an empty block.
        drive(1'b1, 16'hA5A5, 1'b1, 1'b0);
        chk("ft_wr_en",   32'(bus.ram_wr_en), 1);
        chk("ft_wr_addr", 32'(bus.ram_wr_addr), 0);
        chk("ft_t_rd_en", 32'(bus.ram_rd_en), 0);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        chk("ft_rd_en",   32'(bus.ram_rd_en), 1);
        chk("ft_rd_addr", 32'(bus.ram_rd_addr), 0);
        chk("ft_vld_t1",  32'(bus.out_valid), 0);
        chk("ft_cnt_t1",  32'(bus.count), 1);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        chk("ft_vld_t2",  32'(bus.out_valid), 1);
        chk("ft_word",    32'(bus.out_word), 32'hA5A5);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        chk("ft_cnt_t3",  32'(bus.count), 0);
        chk("ft_empty",   32'(bus.empty), 1);

        // Fill to DEPTH+1 with the consumer stalled, then drain across the pointer wrap.
        for (int i = 0; i < 33; i++) begin
            drive(1'b1, 16'(16'h1000 + i), 1'b0, 1'b0);
            chk("fill_in_ready", 32'(bus.in_ready), 1);
        end
        drive(1'b1, 16'hDEAD, 1'b0, 1'b0);
        chk("fill_count", 32'(bus.count), 33);
        chk("fill_full",  32'(bus.full), 1);
        chk("fill_in_rdy", 32'(bus.in_ready), 0);
        chk("fill_wr_en", 32'(bus.ram_wr_en), 0);
        chk("fill_rd_en", 32'(bus.ram_rd_en), 0);
        for (int i = 0; i < 33; i++) begin
            drive(1'b0, 16'h0, 1'b1, 1'b0);
            chk("drain_vld",  32'(bus.out_valid), 1);
            chk("drain_word", 32'(bus.out_word), 32'(16'h1000 + i));
            if (i == 0) chk("drain_in_rdy_same", 32'(bus.in_ready), 0);
            if (i == 1) chk("drain_in_rdy_next", 32'(bus.in_ready), 1);
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        chk("drain_count", 32'(bus.count), 0);
        chk("drain_empty", 32'(bus.empty), 1);

        // Stalled head stays put and blocks reads.
        for (int i = 0; i < 3; i++) drive(1'b1, 16'(1 + i), 1'b0, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld",   32'(bus.out_valid), 1);
            chk("bp_word",  32'(bus.out_word), 1);
            chk("bp_rd_en", 32'(bus.ram_rd_en), 0);
            drive(1'b0, 16'h0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h0, 1'b1, 1'b0);
            chk("bp_rel_word", 32'(bus.out_word), 32'(1 + i));
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        chk("bp_empty", 32'(bus.empty), 1);

        // Streaming: one word per cycle each way after a 2-cycle fill.
        for (int k = 0; k < 102; k++) begin
            drive(k < 100, 16'(16'h2000 + k), 1'b1, 1'b0);
            if (k == 1) chk("st_count_fill", 32'(bus.count), 1);
            if (k >= 2) begin
                chk("st_vld",  32'(bus.out_valid), 1);
                chk("st_word", 32'(bus.out_word), 32'(16'h2000 + k - 2));
            end
            if (k >= 2 && k < 100) chk("st_count", 32'(bus.count), 2);
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        chk("st_empty", 32'(bus.empty), 1);

        // Flush with ten words held and a concurrent write offer.
        for (int i = 0; i < 10; i++) drive(1'b1, 16'(16'h3000 + i), 1'b0, 1'b0);
        drive(1'b1, 16'h3FFF, 1'b0, 1'b1);
        chk("fl_pre_count", 32'(bus.count), 10);
        chk("fl_wr_en",     32'(bus.ram_wr_en), 0);
        chk("fl_rd_en",     32'(bus.ram_rd_en), 0);
        chk("fl_in_ready",  32'(bus.in_ready), 0);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        chk("fl_count",     32'(bus.count), 0);
        chk("fl_out_valid", 32'(bus.out_valid), 0);
        drive(1'b1, 16'h4444, 1'b1, 1'b0);
        chk("fl_wr_addr",   32'(bus.ram_wr_addr), 0);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        chk("fl_rd_addr",   32'(bus.ram_rd_addr), 0);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        chk("fl_new_word",  32'(bus.out_word), 32'h4444);

        // Asynchronous reset in the middle of a stream.
        for (int k = 0; k < 5; k++) drive(1'b1, 16'(16'h5000 + k), 1'b1, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("ar_count",     32'(bus.count), 0);
        chk("ar_out_valid", 32'(bus.out_valid), 0);
        chk("ar_rd_en",     32'(bus.ram_rd_en), 0);
        chk("ar_wr_en",     32'(bus.ram_wr_en), 0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        chk("ar_in_ready",  32'(bus.in_ready), 1);
        chk("ar_empty",     32'(bus.empty), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Pointer/flow-control front end that turns the dispatcher's registered two-port RAM (ram_2_port) into a first-word-fall-through FIFO with valid/ready handshakes on both sides. It sits directly in front of the RAM and drives its write and read ports. It consumes the RAM's one-cycle registered read data and presents it to the downstream dispatcher stage. Capacity is DEPTH words in RAM plus one word held on the RAM read register.

## Interface
Parameters:
- WORD_SIZE, 16, data word width; must match the RAM.
- ADDR_SIZE, 5, RAM address width.
- DEPTH, 2**ADDR_SIZE, RAM entries; must equal 2**ADDR_SIZE so pointers wrap naturally.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all contents; wins over every other input.
- in_valid  in  1  producer offers in_word.
- in_word  in  WORD_SIZE  producer data.
- in_ready  out  1  space available; transfer when in_valid && in_ready.
- out_valid  out  1  out_word is valid.
- out_word  out  WORD_SIZE  head word; wired directly from ram_rd_word.
- out_ready  in  1  consumer accepts; pop when out_valid && out_ready.
- count  out  ADDR_SIZE+1  words held, 0..DEPTH+1.
- empty / full  out  1 each  count==0 / in_ready==0.
- ram_wr_en, ram_wr_addr[ADDR_SIZE], ram_wr_word[WORD_SIZE]  out  RAM write port.
- ram_rd_en, ram_rd_addr[ADDR_SIZE]  out  RAM read port.
- ram_rd_word  in  WORD_SIZE  RAM registered read data.

## Operation
- State: wr_ptr, rd_ptr (ADDR_SIZE, wrap mod DEPTH), ram_cnt (ADDR_SIZE+1, words resident in RAM), head_vld (ram_rd_word holds an unconsumed word).
- Write: in_ready = (ram_cnt != DEPTH) && !flush. On push: ram_wr_en=1, ram_wr_addr=wr_ptr, ram_wr_word=in_word, wr_ptr++.
- Read issue: rd_go = (ram_cnt != 0) && (!head_vld || out_ready) && !flush. On rd_go: ram_rd_en=1, ram_rd_addr=rd_ptr, rd_ptr++.
- head_vld next = rd_go ? 1 : (out_ready ? 0 : head_vld). out_valid = head_vld.
- ram_cnt next = ram_cnt + push - rd_go; simultaneous push and rd_go leaves it unchanged.
- count = ram_cnt + head_vld (combinational). empty = (count==0). full = !in_ready.
- RAM outputs are combinational from registered state plus handshake inputs. ram_rd_en must never assert while the held head word is neither consumed nor invalid, because the RAM read register is the output holding register.
- flush: next cycle wr_ptr=rd_ptr=0, ram_cnt=0, head_vld=0. No RAM write or read is issued in the flush cycle.
- Reset (rst low, asynchronous): wr_ptr=rd_ptr=0, ram_cnt=0, head_vld=0. Hence out_valid=0, count=0, empty=1, full=0, in_ready=1 once released, and ram_wr_en=ram_rd_en=0. Reset mid-operation discards all contents.

## Timing
- Fall-through latency into an empty block: push in cycle t, rd_go in t+1, out_valid=1 in t+2.
- Read-before-write: a word pushed in cycle t is never read in t, because ram_cnt is registered. No same-address hazard exists.
- Steady state with in_valid and out_ready held high gives one word per cycle in each direction.
- in_ready does not rise in the same cycle as a pop; space freed by rd_go is visible the next cycle.
- out_word is stable while out_valid && !out_ready, since no read is issued.

## Structure
- No sub-module. The RAM stays a sibling instance in the parent, with the parent inverting rst for the RAM's active-high reset.
- DEPTH/ADDR_SIZE consistency check and count-width constant belong in the shared dispatcher package.

## Test plan
- Reset then idle: out_valid=0, count=0, empty=1, in_ready=1, ram_wr_en=ram_rd_en=0.
- Push 0xA5A5 at t into an empty block with out_ready=1: ram_rd_en at t+1 with addr 0, out_valid at t+2 with out_word=0xA5A5, count returns to 0 at t+3.
- Fill: push 33 words with out_ready=0, expect count=33, full=1, in_ready=0. Then pop all 33 in order; wr_ptr/rd_ptr wrap from 31 to 0.
- Back-pressure: head=0x0001 with out_ready=0 for 5 cycles: out_word stays 0x0001 and ram_rd_en stays 0. Releasing out_ready pops one word per cycle in order.
- Streaming: in_valid=out_ready=1 for 100 cycles with incrementing data: output is in order with no gaps after 2-cycle fill, and count stays 2.
- Flush with count=10 and concurrent in_valid: no RAM write that cycle, next cycle count=0, out_valid=0. Asserting rst low mid-stream gives the same result immediately.
